// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions,
// handler vector and FSM state type. Also used by the decoder and hazard unit.
package cp0_exc_unit_pkg;

  localparam logic [31:0] HANDLER_PC = 32'h8000_0180;
  localparam int          NUM_INT    = 6;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 10;
  localparam int CA_BD     = 31;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] im;   // Status[15:8]
    logic       exl;
    logic       ie;
  } status_t;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline <-> CP0 exception unit connection bundle.
interface cp0_exc_unit_if;
  import cp0_exc_unit_pkg::*;

  logic               ex_valid;
  logic [31:0]        ex_pc;
  logic               ex_bd;
  logic               ovf;
  logic               eret;
  logic               mtc0;
  logic [4:0]         cp0_addr;
  logic [31:0]        cp0_wdata;
  logic [NUM_INT-1:0] int_req;
  logic [31:0]        cp0_rdata;
  logic               ex_kill;
  logic               flush;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        epc;

  modport master (
    output ex_valid, ex_pc, ex_bd, ovf, eret, mtc0, cp0_addr, cp0_wdata, int_req,
    input  cp0_rdata, ex_kill, flush, redirect, redirect_pc, epc
  );

  modport slave (
    input  ex_valid, ex_pc, ex_bd, ovf, eret, mtc0, cp0_addr, cp0_wdata, int_req,
    output cp0_rdata, ex_kill, flush, redirect, redirect_pc, epc
  );

endinterface

// File: rtl/cp0_exc_unit_int_sync.sv
// Two-flop synchronizer for the asynchronous, level-sensitive interrupt lines.
module cp0_exc_unit_int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs at the same edge and the chain really is two deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: decides commit / exception / ERET for the EX instruction,
// holds Status/Cause/EPC and drives kill, flush and PC redirect.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
(
  input logic          clk,
  input logic          rst,
  cp0_exc_unit_if.slave bus
);

  state_t             state, state_nxt;
  status_t            status;
  logic               cause_bd;
  logic [4:0]         exc_code;
  logic [31:0]        epc;
  logic [31:0]        target;
  logic [NUM_INT-1:0] ip;

  logic take_int, take_exc, do_eret, do_mtc0;

  cp0_exc_unit_int_sync #(.WIDTH(NUM_INT)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.int_req),
    .q   (ip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    take_int  = 1'b0;
    take_exc  = 1'b0;
    do_eret   = 1'b0;
    do_mtc0   = 1'b0;
    case (state)
      RUN: begin
        if (bus.ex_valid) begin
          // IP[15:10] lines up with IM[15:10], the top six mask bits.
          take_int  = status.ie & ~status.exl & (|(ip & status.im[7:2]));
          take_exc  = take_int | bus.ovf;
          do_eret   = ~take_exc & bus.eret;
          do_mtc0   = ~take_exc & ~bus.eret & bus.mtc0;
          if (take_exc || do_eret) state_nxt = REDIR;
        end
      end
      REDIR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign bus.ex_kill     = take_exc;
  assign bus.flush       = (state == REDIR);
  assign bus.redirect    = (state == REDIR);
  assign bus.redirect_pc = target;
  assign bus.epc         = epc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status   <= '0;
      cause_bd <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
      target   <= '0;
    end else if (take_exc) begin
      exc_code <= take_int ? EXC_INT : EXC_OV;
      target   <= HANDLER_PC;
      // A nested exception keeps the EPC/BD of the outermost one.
      if (!status.exl) begin
        epc        <= exc_epc(bus.ex_pc, bus.ex_bd);
        cause_bd   <= bus.ex_bd;
        status.exl <= 1'b1;
      end
    end else if (do_eret) begin
      status.exl <= 1'b0;
      target     <= epc;
    end else if (do_mtc0) begin
      case (bus.cp0_addr)
        CP0_STATUS: begin
          status.im  <= bus.cp0_wdata[ST_IM_LO +: 8];
          status.exl <= bus.cp0_wdata[ST_EXL];
          status.ie  <= bus.cp0_wdata[ST_IE];
        end
        CP0_CAUSE: begin
          cause_bd <= bus.cp0_wdata[CA_BD];
          exc_code <= bus.cp0_wdata[CA_EXC_LO +: 5];
        end
        CP0_EPC: epc <= bus.cp0_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      CP0_STATUS: bus.cp0_rdata = {16'b0, status.im, 6'b0, status.exl, status.ie};
      CP0_CAUSE:  bus.cp0_rdata = {cause_bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
      CP0_EPC:    bus.cp0_rdata = epc;
      default:    bus.cp0_rdata = '0;
    endcase
  end

endmodule
